// File: rtl/seq_sub256bits.sv
// Multi-cycle unsigned subtractor: one W-bit chunk per clock, LSB chunk first,
// borrow carried between chunks in a register, one-cycle done pulse on completion.
`timescale 1ns/1ps

module seq_sub256bits #(
    parameter int N = 256,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         bin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         busy,
    output logic         done
);

    localparam int NCHUNK = N / W;
    localparam int CNT_W  = $clog2(NCHUNK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic             r_brw;
    logic [N-W-1:0]   r_acc;
    logic [N-1:0]     r_d;
    logic             r_bout;
    logic [W:0]       w_diff;
    logic [N-W-1:0]   w_acc_next;
    logic             w_last;

    // Operands shift right each RUN cycle, so the active chunk is always the low W bits.
    assign w_diff = {1'b0, r_a[W-1:0]} - {1'b0, r_b[W-1:0]} - (W+1)'(r_brw);
    assign w_last = (r_cnt == CNT_W'(NCHUNK - 1));

    // Result chunks enter at the top of the accumulator; the final chunk bypasses it into d.
    generate
        if (NCHUNK == 2) begin : g_acc_two
            assign w_acc_next = w_diff[W-1:0];
        end else begin : g_acc_many
            assign w_acc_next = {w_diff[W-1:0], r_acc[N-W-1:W]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
        d    = r_d;
        bout = r_bout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_brw  <= 1'b0;
            r_acc  <= '0;
            r_d    <= '0;
            r_bout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_brw <= bin;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> W;
                    r_b   <= r_b >> W;
                    r_brw <= w_diff[W];
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_d    <= {w_diff[W-1:0], r_acc};
                        r_bout <= w_diff[W];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sub256bits.sv
// Self-checking bench for seq_sub256bits: directed cases, back-to-back starts,
// mid-run reset and randomized operands against a plain-arithmetic reference.
`timescale 1ns/1ps

module tb_seq_sub256bits;

    localparam int N = 256;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         bin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] d;
    logic         bout;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] prev_d;
    logic         prev_b;

    logic [N-1:0] qa [0:40];
    logic [N-1:0] qb [0:40];
    logic         qc [0:40];

    seq_sub256bits #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .a     (a),
        .b     (b),
        .d     (d),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: full-width subtraction with one extra bit to catch the borrow.
    function automatic logic [N:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - {{N{1'b0}}, c};
    endfunction

    function automatic logic [N-1:0] rand256();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tbv, input logic tbin,
                          input logic [N-1:0] exp_d, input logic exp_b, input string tag);
        int k;
        @(negedge clk);
        a = ta; b = tbv; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = rand256(); b = rand256(); bin = 1'($urandom);
        chk({tag, " busy_after_start"}, N'(busy), N'(1'b1));
        chk({tag, " d_held"}, d, prev_d);
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 3) start = 1'b1;
            if (k == 5) start = 1'b0;
            a = rand256(); b = rand256();
        end
        chk({tag, " latency"}, N'(k), N'(8));
        chk({tag, " d"}, d, exp_d);
        chk({tag, " bout"}, N'(bout), N'(exp_b));
        chk({tag, " busy_in_done"}, N'(busy), N'(1'b1));
        @(negedge clk);
        chk({tag, " done_pulse_width"}, N'(done), N'(1'b0));
        chk({tag, " busy_cleared"}, N'(busy), N'(1'b0));
        chk({tag, " d_stable"}, d, exp_d);
        prev_d = exp_d;
        prev_b = exp_b;
        $display("op %s: d=%h bout=%0b latency=%0d", tag, d, bout, k);
    endtask

    initial begin
        logic [N-1:0] ones;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;
        logic [N:0]   r;
        ones   = '1;
        rst_n  = 1'b0;
        start  = 1'b1;
        bin    = 1'b1;
        a      = ones;
        b      = 1;
        prev_d = '0;
        prev_b = 1'b0;

        // Reset state, with start asserted to show it is ignored under reset
        @(negedge clk);
        @(negedge clk);
        chk("reset d", d, '0);
        chk("reset bout", N'(bout), '0);
        chk("reset busy", N'(busy), '0);
        chk("reset done", N'(done), '0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", N'(busy), '0);

        // Directed cases
        run_op(N'(5), N'(3), 1'b0, N'(2), 1'b0, "t1_5m3");
        run_op(N'(0), N'(1), 1'b0, ones, 1'b1, "t2_0m1");
        run_op(N'(64'h1_0000_0000), N'(1), 1'b0, N'(64'h0000_0000_FFFF_FFFF), 1'b0, "t3_chunk_cross");

        // start held high with operands changing every cycle
        @(negedge clk);
        qa[0] = rand256(); qb[0] = rand256(); qc[0] = 1'($urandom);
        a = qa[0]; b = qb[0]; bin = qc[0]; start = 1'b1;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk);
            chk($sformatf("t4 done_edge%0d", e), N'(done), N'(e % 10 == 8));
            if (e % 10 == 8) begin
                r = ref_sub(qa[e-8], qb[e-8], qc[e-8]);
                chk($sformatf("t4 d_edge%0d", e), d, r[N-1:0]);
                chk($sformatf("t4 bout_edge%0d", e), N'(bout), N'(r[N]));
                prev_d = r[N-1:0];
                prev_b = r[N];
                $display("op t4_b2b edge %0d: d=%h bout=%0b", e, d, bout);
            end
            qa[e+1] = rand256(); qb[e+1] = rand256(); qc[e+1] = 1'($urandom);
            a = qa[e+1]; b = qb[e+1]; bin = qc[e+1];
            if (e == 39) start = 1'b0;
        end

        // Reset during RUN at cnt=4 aborts without a done pulse
        @(negedge clk);
        a = rand256(); b = rand256(); bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5 busy_before_reset", N'(busy), N'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("t5 d_reset", d, '0);
        chk("t5 bout_reset", N'(bout), '0);
        chk("t5 busy_reset", N'(busy), '0);
        chk("t5 done_reset", N'(done), '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t5 no_done_%0d", i), N'(done), '0);
        end
        $display("op t5_abort: d=%h bout=%0b busy=%0b", d, bout, busy);
        prev_d = '0;
        prev_b = 1'b0;
        run_op(N'(10), N'(10), 1'b1, ones, 1'b1, "t5_after_reset");

        // Randomized operands, including equal and all-ones pairs
        for (int i = 0; i < 1000; i++) begin
            ra = rand256();
            rb = rand256();
            rc = 1'($urandom);
            if (i % 10 == 0) rb = ra;
            if (i % 10 == 1) begin ra = ones; rb = ones; end
            if (i % 10 == 2) rb[N-1:N/2] = ra[N-1:N/2];
            r = ref_sub(ra, rb, rc);
            run_op(ra, rb, rc, r[N-1:0], r[N], $sformatf("t6_%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
